// File: rtl/sobel_v3_pkg.sv
// Shared types and constants for the Sobel burst-DMA accelerator.
package sobel_v3_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_CTRL = 3'd1,
        S_READ    = 3'd2,
        S_WR_CTRL = 3'd3,
        S_WRITE   = 3'd4,
        S_DONE    = 3'd5
    } state_e;

    localparam int         BEAT_BYTES    = 8;
    localparam logic [2:0] DMA_SIZE_64   = 3'd3;
    localparam int         DBG_STATE_LSB = 0;
    localparam int         DBG_STATE_W   = 3;
    localparam int         DBG_SIZE_ERR  = 3;

endpackage

// File: rtl/sobel_v3_wbuf.sv
// Output burst buffer: packs edge bytes MSB-first into 64-bit beats.
// Starting a beat zeroes its remaining lanes, so a partial last beat is already padded.
module sobel_v3_wbuf
    import sobel_v3_pkg::*;
#(
    parameter int WR_BURST = 4,
    localparam int BW  = (WR_BURST > 1) ? $clog2(WR_BURST) : 1,
    localparam int NBW = $clog2(WR_BURST * BEAT_BYTES + 1)
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           clr_i,
    input  logic           wr_en_i,
    input  logic [7:0]     wr_byte_i,
    input  logic [BW-1:0]  rd_idx_i,
    output logic [63:0]    rd_beat_o,
    output logic           full_o,
    output logic [NBW-1:0] count_o
);

    localparam logic [NBW-1:0] CAP = NBW'(WR_BURST * BEAT_BYTES);

    logic [63:0]    mem_q [WR_BURST];
    logic [NBW-1:0] bytes_q, bytes_d;
    logic [BW-1:0]  wr_beat;
    logic [2:0]     wr_lane;
    logic [5:0]     wr_lsb;

    assign wr_lane   = bytes_q[2:0];
    assign wr_beat   = BW'(bytes_q >> 3);
    assign wr_lsb    = {~wr_lane, 3'b000};
    assign full_o    = (bytes_q == CAP);
    assign count_o   = bytes_q;
    assign rd_beat_o = mem_q[rd_idx_i];

    always_comb begin
        bytes_d = bytes_q;
        if (clr_i) begin
            bytes_d = '0;
        end else if (wr_en_i && !full_o) begin
            bytes_d = bytes_q + NBW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bytes_q <= '0;
        end else begin
            bytes_q <= bytes_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i && !full_o && !clr_i) begin
            if (wr_lane == 3'd0) begin
                mem_q[wr_beat] <= {wr_byte_i, 56'd0};
            end else begin
                mem_q[wr_beat][wr_lsb +: 8] <= wr_byte_i;
            end
        end
    end

endmodule

// File: rtl/sobel_v3_rtl_burst_dma64.sv
// Sobel edge accelerator: chunked window reads, per-beat edge computation,
// bursted 64-bit result writes over an ESP-style DMA interface.
module sobel_v3_rtl_burst_dma64
    import sobel_v3_pkg::*;
#(
    parameter int MAX_PIXELS = 4096,
    parameter int RD_CHUNK   = 64,
    parameter int WR_BURST   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] conf_info_width,
    input  logic [31:0] conf_info_height,
    input  logic        conf_info_mode,
    input  logic [7:0]  conf_info_threshold,
    input  logic        conf_done,
    output logic        dma_read_ctrl_valid,
    output logic [31:0] dma_read_ctrl_data_index,
    output logic [31:0] dma_read_ctrl_data_length,
    output logic [2:0]  dma_read_ctrl_data_size,
    input  logic        dma_read_ctrl_ready,
    output logic        dma_read_chnl_ready,
    input  logic        dma_read_chnl_valid,
    input  logic [63:0] dma_read_chnl_data,
    output logic        dma_write_ctrl_valid,
    output logic [31:0] dma_write_ctrl_data_index,
    output logic [31:0] dma_write_ctrl_data_length,
    output logic [2:0]  dma_write_ctrl_data_size,
    input  logic        dma_write_ctrl_ready,
    input  logic        dma_write_chnl_ready,
    output logic        dma_write_chnl_valid,
    output logic [63:0] dma_write_chnl_data,
    output logic        acc_done,
    output logic [31:0] debug
);

    localparam int BW  = (WR_BURST > 1) ? $clog2(WR_BURST) : 1;
    localparam int NBW = $clog2(WR_BURST * BEAT_BYTES + 1);

    function automatic logic [7:0] sat_u8(input logic [11:0] v);
        return (|v[11:8]) ? 8'hFF : v[7:0];
    endfunction

    function automatic logic [11:0] abs12(input logic signed [11:0] v);
        return v[11] ? 12'(-v) : 12'(v);
    endfunction

    // Magnitude approximated as |gx|+|gy|, saturated to a byte.
    function automatic logic [7:0] sobel_filter(input logic [63:0] w);
        logic [7:0]         lu, cu, ru, lc, rc, lb, cb, rb;
        logic [11:0]        xp, xn, yp, yn;
        logic signed [11:0] gx, gy;
        {lu, cu, ru, lc, rc, lb, cb, rb} = w;
        xp = 12'(ru) + 12'(rb) + {3'd0, rc, 1'b0};
        xn = 12'(lu) + 12'(lb) + {3'd0, lc, 1'b0};
        yp = 12'(lb) + 12'(rb) + {3'd0, cb, 1'b0};
        yn = 12'(lu) + 12'(ru) + {3'd0, cu, 1'b0};
        gx = $signed(xp) - $signed(xn);
        gy = $signed(yp) - $signed(yn);
        return sat_u8(abs12(gx) + abs12(gy));
    endfunction

    state_e         state_q, state_d;
    logic [31:0]    num_pix_q, num_pix_d, rd_req_q, rd_req_d, pix_acc_q, pix_acc_d;
    logic [31:0]    chunk_left_q, chunk_left_d, wr_beats_q, wr_beats_d;
    logic [BW-1:0]  send_idx_q, send_idx_d;
    logic           mode_q, mode_d, size_err_q, size_err_d;
    logic [7:0]     thr_q, thr_d;
    logic [31:0]    frame_px, rd_rem, rd_len;
    logic [NBW-1:0] buf_count, buf_count_p7;
    logic [BW:0]    beats_held;
    logic           buf_full, buf_clr, buf_wr;
    logic [63:0]    buf_beat;
    logic [7:0]     edge_lum, out_byte;

    assign frame_px     = conf_info_width * conf_info_height;
    assign rd_rem       = num_pix_q - rd_req_q;
    assign rd_len       = (rd_rem > 32'(RD_CHUNK)) ? 32'(RD_CHUNK) : rd_rem;
    assign buf_count_p7 = buf_count + NBW'(BEAT_BYTES - 1);
    assign beats_held   = (BW+1)'(buf_count_p7 >> 3);
    assign edge_lum     = sobel_filter(dma_read_chnl_data);
    assign out_byte     = mode_q ? ((edge_lum >= thr_q) ? 8'hFF : 8'h00) : edge_lum;

    sobel_v3_wbuf #(.WR_BURST(WR_BURST)) u_wbuf (
        .clk_i     (clk),
        .rst_ni    (rst),
        .clr_i     (buf_clr),
        .wr_en_i   (buf_wr),
        .wr_byte_i (out_byte),
        .rd_idx_i  (send_idx_q),
        .rd_beat_o (buf_beat),
        .full_o    (buf_full),
        .count_o   (buf_count)
    );

    // Handshake outputs decode the registered state; buses read zero when idle.
    assign dma_read_ctrl_valid        = (state_q == S_RD_CTRL);
    assign dma_read_ctrl_data_index   = dma_read_ctrl_valid ? rd_req_q : '0;
    assign dma_read_ctrl_data_length  = dma_read_ctrl_valid ? rd_len : '0;
    assign dma_read_ctrl_data_size    = DMA_SIZE_64;
    assign dma_read_chnl_ready        = (state_q == S_READ) && !buf_full;
    assign dma_write_ctrl_valid       = (state_q == S_WR_CTRL);
    assign dma_write_ctrl_data_index  = dma_write_ctrl_valid ? wr_beats_q : '0;
    assign dma_write_ctrl_data_length = dma_write_ctrl_valid ? 32'(beats_held) : '0;
    assign dma_write_ctrl_data_size   = DMA_SIZE_64;
    assign dma_write_chnl_valid       = (state_q == S_WRITE);
    assign dma_write_chnl_data        = dma_write_chnl_valid ? buf_beat : '0;
    assign acc_done                   = (state_q == S_DONE);

    always_comb begin
        debug = '0;
        debug[DBG_STATE_LSB +: DBG_STATE_W] = state_q;
        debug[DBG_SIZE_ERR] = size_err_q;
    end

    always_comb begin
        state_d      = state_q;
        num_pix_d    = num_pix_q;
        rd_req_d     = rd_req_q;
        pix_acc_d    = pix_acc_q;
        chunk_left_d = chunk_left_q;
        wr_beats_d   = wr_beats_q;
        send_idx_d   = send_idx_q;
        mode_d       = mode_q;
        thr_d        = thr_q;
        size_err_d   = size_err_q;
        buf_clr      = 1'b0;
        buf_wr       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (conf_done) begin
                    num_pix_d    = frame_px;
                    rd_req_d     = '0;
                    pix_acc_d    = '0;
                    chunk_left_d = '0;
                    wr_beats_d   = '0;
                    send_idx_d   = '0;
                    mode_d       = conf_info_mode;
                    thr_d        = conf_info_threshold;
                    size_err_d   = (frame_px > 32'(MAX_PIXELS));
                    buf_clr      = 1'b1;
                    state_d      = ((frame_px == '0) || (frame_px > 32'(MAX_PIXELS))) ? S_DONE : S_RD_CTRL;
                end
            end
            S_RD_CTRL: begin
                if (dma_read_ctrl_ready) begin
                    rd_req_d     = rd_req_q + rd_len;
                    chunk_left_d = rd_len;
                    state_d      = S_READ;
                end
            end
            S_READ: begin
                if (dma_read_chnl_valid && dma_read_chnl_ready) begin
                    buf_wr       = 1'b1;
                    pix_acc_d    = pix_acc_q + 32'd1;
                    chunk_left_d = chunk_left_q - 32'd1;
                    // A full buffer or the frame's last pixel wins over an exhausted chunk.
                    if ((buf_count == NBW'(WR_BURST * BEAT_BYTES - 1)) || (pix_acc_d == num_pix_q)) begin
                        state_d = S_WR_CTRL;
                    end else if (chunk_left_q == 32'd1) begin
                        state_d = S_RD_CTRL;
                    end
                end
            end
            S_WR_CTRL: begin
                if (dma_write_ctrl_ready) begin
                    send_idx_d = '0;
                    state_d    = S_WRITE;
                end
            end
            S_WRITE: begin
                if (dma_write_chnl_ready) begin
                    wr_beats_d = wr_beats_q + 32'd1;
                    send_idx_d = send_idx_q + BW'(1);
                    if ({1'b0, send_idx_q} == beats_held - (BW+1)'(1)) begin
                        buf_clr = 1'b1;
                        if (pix_acc_q == num_pix_q) begin
                            state_d = S_DONE;
                        end else if (chunk_left_q != '0) begin
                            state_d = S_READ;
                        end else begin
                            state_d = S_RD_CTRL;
                        end
                    end
                end
            end
            S_DONE: begin
                if (!conf_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            num_pix_q    <= '0;
            rd_req_q     <= '0;
            pix_acc_q    <= '0;
            chunk_left_q <= '0;
            wr_beats_q   <= '0;
            send_idx_q   <= '0;
            mode_q       <= 1'b0;
            thr_q        <= '0;
            size_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_pix_q    <= num_pix_d;
            rd_req_q     <= rd_req_d;
            pix_acc_q    <= pix_acc_d;
            chunk_left_q <= chunk_left_d;
            wr_beats_q   <= wr_beats_d;
            send_idx_q   <= send_idx_d;
            mode_q       <= mode_d;
            thr_q        <= thr_d;
            size_err_q   <= size_err_d;
        end
    end

endmodule

// File: doc/sobel_v3_rtl_burst_dma64.md
# sobel_v3_rtl_burst_dma64

Parametrised Sobel edge accelerator with chunked DMA reads, burst DMA writes and a selectable binary-threshold output mode. It sits behind the ESP-style 64-bit DMA interface. Each read beat carries one pre-gathered 3x3 window: 8 neighbour bytes, centre excluded. Each output beat packs eight edge bytes, and up to WR_BURST beats are buffered and written per write request.

## Interface
- MAX_PIXELS, 4096, largest legal frame (width*height)
- RD_CHUNK, 64, maximum windows (read beats) per read request; ≥1
- WR_BURST, 4, output beats buffered per write request; power of 2, ≥1
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset; one clock, asynchronous, active-low
- conf_info_width, conf_info_height  in  32 each  frame dimensions
- conf_info_mode  in  1  0 = raw magnitude, 1 = binary threshold
- conf_info_threshold  in  8  threshold for mode 1
- conf_done  in  1  configuration valid; level, sampled in S_IDLE
- dma_read_ctrl_{valid,data_index,data_length,data_size,ready}  out/out/out/out/in  1/32/32/3/1  read request
- dma_read_chnl_{ready,valid,data}  out/in/in  1/1/64  read data
- dma_write_ctrl_{valid,data_index,data_length,data_size,ready}  out/out/out/out/in  1/32/32/3/1  write request
- dma_write_chnl_{ready,valid,data}  in/out/out  1/1/64  write data
- acc_done  out  1  frame complete, level
- debug  out  32  [2:0] state, [3] size error, rest 0

## Operation
- **Frame size.** num_pixels = width*height, truncated to 32 bits and latched on leaving S_IDLE.
  - num_pixels==0 or >MAX_PIXELS: go straight to S_DONE with no DMA traffic.
  - debug[3]=1 only for the >MAX_PIXELS case.
- **States.** S_IDLE, S_RD_CTRL, S_READ, S_WR_CTRL, S_WRITE, S_DONE.
- **S_IDLE.** On conf_done=1, clear counters and the buffer, then go to S_RD_CTRL (or S_DONE per the size rule).
- **S_RD_CTRL.** dma_read_ctrl_valid=1 with:
  - index = windows already requested
  - length = min(RD_CHUNK, num_pixels − requested)
  - size = 3'd3
  - On ready, go to S_READ with chunk_left = length.
- **S_READ.** dma_read_chnl_ready = !buf_full.
  - Each accepted beat goes through SobelFilter combinationally in the same cycle. Byte map: data[63:56]=lu, then cu, ru, lc, rc, lb, cb, data[7:0]=rb.
  - Result byte: mode 0 = edge_lum; mode 1 = (edge_lum ≥ threshold) ? 8'hFF : 8'h00.
  - Pixel p is stored in beat p/8, bits [63−8*(p%8) -: 8].
- **Leaving S_READ.** Move to S_WR_CTRL when either:
  - the buffer holds WR_BURST full beats, or
  - the final pixel has been accepted. A partial last beat is zero-padded.
  - Otherwise, when chunk_left reaches 0, go to S_RD_CTRL.
- **S_WR_CTRL.** dma_write_ctrl_valid=1 with:
  - index = output beats already written
  - length = beats held (WR_BURST, or fewer at frame end)
  - size = 3'd3
  - On ready, go to S_WRITE.
- **S_WRITE.** Beats are sent in order and each is held stable until dma_write_chnl_ready. After the last beat, clear the buffer, then:
  - all pixels written → S_DONE
  - chunk_left>0 → S_READ
  - else → S_RD_CTRL
- **S_DONE.** acc_done=1. When conf_done drops, return to S_IDLE and clear acc_done. conf_done changes at any other time are ignored.
- **Reset.** Reset asserted mid-frame aborts immediately. Every valid, acc_done and debug go to 0, state goes to S_IDLE, and buffer contents are discarded.

## Timing
- **Reset values.** All outputs 0, including data/index/length buses. The size buses are constants 3'd3.
- **Latency.** Zero from read-beat acceptance to byte deposit. One beat is accepted per cycle at most.
- **Control handshakes.** Valid is asserted the cycle after state entry and held, with fields stable, until ready. Transfer happens on the cycle valid&ready; the next state follows on the next edge.
- **Channel handshakes.** Beat transfer on valid&ready. No combinational path from ready to valid.
- **Simultaneous events.** When the buffer fills on the last beat of a chunk, writing takes priority. The next read request is issued only after the write completes.
- **Output size.** Total write beats = ceil(num_pixels/8). Write requests = ceil(beats/WR_BURST).

## Structure
- **Package sobel_v3_pkg.** Holds the state enum, BEAT_BYTES=8, DMA_SIZE_64=3'd3, and the debug field positions.
- **Sub-module sobel_v3_wbuf.** WR_BURST×64 burst buffer with byte packer. Provides byte-write, zero-pad, beat-read and clear, plus full and count outputs.
- **Top level.** Holds the FSM, the counters and the existing combinational SobelFilter.

## Test plan
- **Zero-padded partial frame.** 4x4 frame, all windows uniform 0x40, mode 0, WR_BURST=4 → one read request (0, 16). One write request (0, 2). Two beats of 0x0000000000000000. acc_done=1.
- **Threshold mode, partial beat.** 5x2 frame, uniform windows, mode 1, threshold 0 → one write of length 2. Beat0 = 0xFFFF…FF. Beat1 = 0xFFFF000000000000.
- **Chunk and burst interleave.** 24x24 frame, RD_CHUNK=64, WR_BURST=4 → the buffer fills mid-chunk after 32 pixels, so writes interleave with reads. Result: 9 read requests, 18 write requests (indices 0,4,…,68), 72 beats.
- **Backpressure.** Random ready stalls on all four DMA ports → data bit-identical to the no-stall run. Valid and payload are held during stalls.
- **Illegal sizes.** 100x100 frame → no DMA valid ever asserted. acc_done=1, debug[3]=1. 0x7 frame → acc_done=1, debug[3]=0.
- **Reset mid-frame.** Assert rst mid-S_READ → all outputs 0 within the same cycle. A clean rerun of the 4x4 case matches the first scenario exactly.
